// File: rtl/vga_grid_capture.sv
// vga_grid_capture: rebuilds a 4x4 alive board from a VESA-style video stream
// (Hsync/Vsync/rgb) and publishes one snapshot per complete frame.
module vga_grid_capture #(
    parameter int unsigned H_BP       = 248,
    parameter int unsigned V_BP       = 38,
    parameter int unsigned H_ACTIVE   = 1280,
    parameter int unsigned V_ACTIVE   = 1024,
    parameter int unsigned X0         = 0,
    parameter int unsigned Y0         = 0,
    parameter int unsigned CELL_W     = 320,
    parameter int unsigned CELL_H     = 256,
    parameter logic [11:0] ALIVE_MASK = 12'hFFF,
    parameter int unsigned H_TIMEOUT  = 4095
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        Hsync,
    input  logic        Vsync,
    input  logic [11:0] rgb,
    output logic [15:0] alive,
    output logic        frame_valid,
    output logic        locked,
    output logic        err_incomplete
);

    localparam logic [0:0]  SEEK    = 1'b0;
    localparam logic [0:0]  CAPTURE = 1'b1;
    localparam logic [11:0] H_MAX   = '1;
    localparam logic [10:0] V_MAX   = '1;
    localparam logic [11:0] H_TO    = 12'(H_TIMEOUT);

    logic        hs1, hs2, vs1, vs2;
    logic [11:0] rgb1;
    logic        h_rise, v_rise, v_fall;
    logic [11:0] hcnt;
    logic [10:0] vcnt;
    logic [31:0] hx, vy;
    logic        active;
    logic [15:0] hit;
    logic        pix_alive;
    logic [0:0]  state;
    logic [15:0] seen, shadow;
    logic [15:0] pub_alive;
    logic        pub_valid, pub_err, lock_q;

    // Input stage: sync and pixel share s1 so they stay aligned; sync gets a second stage for edges.
    always_ff @(posedge clk) begin
        if (reset) begin
            hs1  <= 1'b1;
            vs1  <= 1'b1;
            hs2  <= 1'b1;
            vs2  <= 1'b1;
            rgb1 <= '0;
        end else begin
            hs1  <= Hsync;
            vs1  <= Vsync;
            rgb1 <= rgb;
            hs2  <= hs1;
            vs2  <= vs1;
        end
    end

    assign h_rise    = hs1 & ~hs2;
    assign v_rise    = vs1 & ~vs2;
    assign v_fall    = ~vs1 & vs2;
    assign pix_alive = |(rgb1 & ALIVE_MASK);

    // Horizontal/vertical position counters, saturating; a Vsync rise overrides the line increment.
    always_ff @(posedge clk) begin
        if (reset) begin
            hcnt <= '0;
            vcnt <= '0;
        end else begin
            if (h_rise)
                hcnt <= '0;
            else if (hcnt != H_MAX)
                hcnt <= hcnt + 12'd1;

            if (v_rise)
                vcnt <= '0;
            else if (h_rise && vcnt != V_MAX)
                vcnt <= vcnt + 11'd1;
        end
    end

    assign hx     = {20'd0, hcnt};
    assign vy     = {21'd0, vcnt};
    assign active = (hx >= H_BP) && (hx < H_BP + H_ACTIVE) &&
                    (vy >= V_BP) && (vy < V_BP + V_ACTIVE);

    // Flag which cell, if any, has its centre sample at the current position.
    always_comb begin
        hit = '0;
        for (int unsigned r = 0; r < 4; r++) begin
            for (int unsigned c = 0; c < 4; c++) begin
                if (active &&
                    (hx - H_BP) == (X0 + c * CELL_W + CELL_W / 2) &&
                    (vy - V_BP) == (Y0 + r * CELL_H + CELL_H / 2))
                    hit[4'(r * 4 + c)] = 1'b1;
            end
        end
    end

    // Frame capture FSM: collect samples between Vsync edges and decide publish / error / timeout.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= SEEK;
            seen      <= '0;
            shadow    <= '0;
            pub_alive <= '0;
            pub_valid <= 1'b0;
            pub_err   <= 1'b0;
            lock_q    <= 1'b0;
        end else begin
            pub_valid <= 1'b0;
            pub_err   <= 1'b0;
            case (state)
                SEEK: begin
                    if (v_rise) begin
                        seen   <= '0;
                        shadow <= '0;
                        state  <= CAPTURE;
                    end
                end
                CAPTURE: begin
                    if (v_fall) begin
                        if (seen == '1) begin
                            pub_alive <= shadow;
                            pub_valid <= 1'b1;
                            lock_q    <= 1'b1;
                            seen      <= '0;
                        end else begin
                            pub_err <= 1'b1;
                            lock_q  <= 1'b0;
                            state   <= SEEK;
                        end
                    end else if (hcnt == H_TO) begin
                        lock_q <= 1'b0;
                        state  <= SEEK;
                    end else begin
                        seen   <= seen | hit;
                        shadow <= (shadow & ~hit) | (hit & {16{pix_alive}});
                    end
                end
                default: state <= SEEK;
            endcase
        end
    end

    // Output register: results reach the ports two edges after Vsync low is first sampled.
    always_ff @(posedge clk) begin
        if (reset) begin
            alive          <= '0;
            frame_valid    <= 1'b0;
            locked         <= 1'b0;
            err_incomplete <= 1'b0;
        end else begin
            alive          <= pub_alive;
            frame_valid    <= pub_valid;
            locked         <= lock_q;
            err_incomplete <= pub_err;
        end
    end

endmodule

// File: doc/vga_grid_capture.md
# vga_grid_capture

Receive-side decoder for the VESA video stream driven by the Game of Life display path. It watches Hsync, Vsync and the 12-bit rgb bus and rebuilds the 4x4 board as a 16-bit alive vector, publishing one snapshot per frame. Use it as a loopback checker in the board top, or as a scoreboard front end in simulation, alongside the monitor driver and 4x4 renderer.

## Interface
Parameters:
- H_BP, 248: pixel clocks from Hsync rising edge (end of pulse) to active x=0
- V_BP, 38: Hsync rising edges from Vsync rising edge to active y=0
- H_ACTIVE, 1280: active pixels per line
- V_ACTIVE, 1024: active lines per frame
- X0 / Y0, 0 / 0: grid origin in active pixels
- CELL_W / CELL_H, 320 / 256: cell size in pixels
- ALIVE_MASK, 12'hFFF: a sampled pixel is alive iff (rgb & ALIVE_MASK) != 0
- H_TIMEOUT, 4095: pixel clocks without an Hsync rising edge before lock is lost

Ports:
- clk  in  1  pixel clock, one pixel per cycle
- reset  in  1  synchronous, active-high
- Hsync  in  1  horizontal sync, active-low pulse
- Vsync  in  1  vertical sync, active-low pulse
- rgb  in  12  pixel colour {r[3:0], g[3:0], b[3:0]}
- alive  out  16  last complete board; bit r*4+c is row r, column c
- frame_valid  out  1  one-cycle pulse when alive updates
- locked  out  1  high while consecutive frames decode completely
- err_incomplete  out  1  one-cycle pulse when a frame ends with unsampled cells

## Operation
- Input stage: Hsync, Vsync and rgb are registered together (s1). Sync is registered again (s2). Rising edge means s2=0 and s1=1. Falling edge means s2=1 and s1=0. All decode uses the s1 values.
- hcnt (12 bit): cleared on an Hsync rising edge, otherwise increments. It saturates at 4095 and never wraps.
- vcnt (11 bit): cleared on a Vsync rising edge, incremented on each Hsync rising edge, saturates at 2047. If Vsync and Hsync rise in the same cycle, the Vsync clear wins and vcnt=0.
- Active position: x = hcnt − H_BP, y = vcnt − V_BP. A pixel is active only when H_BP ≤ hcnt < H_BP+H_ACTIVE and V_BP ≤ vcnt < V_BP+V_ACTIVE.
- Sample point for cell (r,c): x = X0 + c·CELL_W + CELL_W/2, y = Y0 + r·CELL_H + CELL_H/2, using integer division. When an active pixel matches a sample point:
  - shadow[r*4+c] takes the alive result for s1 rgb
  - seen[r*4+c] is set
- FSM has states SEEK, CAPTURE.
  - SEEK: on a Vsync rising edge, clear seen and shadow and go to CAPTURE.
  - CAPTURE, Vsync falling edge (end of frame), seen == 16'hFFFF: alive ← shadow, pulse frame_valid, set locked, clear seen.
  - CAPTURE, Vsync falling edge, seen != 16'hFFFF: pulse err_incomplete, clear locked, go to SEEK. alive holds its value.
  - CAPTURE, hcnt reaches H_TIMEOUT: clear locked, go to SEEK, no pulses.
- A Vsync rising edge seen in CAPTURE starts the next frame's counting only. The seen clear happens at the falling edge.

## Timing
- Reset values: alive=0, frame_valid=0, locked=0, err_incomplete=0, FSM=SEEK, hcnt=0, vcnt=0, seen=0, shadow=0.
- Reset mid-frame drops all partial capture. The first publish needs one full Vsync rising-to-falling frame after reset is released.
- Latency: let edge E be the first clk edge that samples Vsync low at the pin.
  - alive, frame_valid and err_incomplete change on edge E+2: one cycle for the s1 register, one for the output register.
  - frame_valid and err_incomplete are high for exactly one cycle.
- Pixel alignment: an rgb value present at the pin in the same cycle as hcnt/vcnt decoding is judged against that same position, because rgb and sync share the s1 stage.
- Throughput: one publish per frame at most, with no backpressure.

## Test plan
- Reset, then two frames of all-black rgb with nominal sync: frame_valid pulses once per frame, alive=16'h0000, locked=1 after the first Vsync fall.
- Render board 16'hA5C3 (cell bit set ⇒ rgb=12'h0F0, else 12'h000): alive=16'hA5C3 on edge E+2 of the next frame end, frame_valid high for exactly one cycle.
- Change the board to 16'h0001 mid-frame, after row 0 has been sampled: that frame publishes 16'h0000. The following frame publishes 16'h0001.
- Truncate a frame so Vsync falls after only 2 cell rows: err_incomplete pulses, locked=0, alive keeps its previous value. The next good frame restores locked=1.
- Stop Hsync for 4095 clocks during CAPTURE: locked drops with no frame_valid. Assert reset mid-frame: all outputs are 0 on the next cycle.
- Drive Vsync and Hsync rising in the same cycle: vcnt=0. Sampling of row 0 still occurs on line V_BP + Y0 + CELL_H/2 = 166.
